ddr3_pg_arbiter: RTL and testbench

DDR3_PG_ARBITER -- requirements
Module: ddr3_pg_arbiter

---
 rtl/ddr3_pg_pkg.sv | 28 ++
 rtl/ddr3_pg_arbiter_rr_pick.sv | 30 +++
 rtl/ddr3_pg_arbiter.sv | 148 ++++++++++++++
 tb/tb_ddr3_pg_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pg_pkg.sv
// Shared definitions for the DDR3 page-transfer arbiter: FSM encoding,
// operation codes, address geometry and a small index helper.
package ddr3_pg_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_XFER     = 2'd1,
    S_XFER_END = 2'd2,
    S_REQ_ACK  = 2'd3
  } state_t;

  localparam logic OPREAD  = 1'b0;  // DDR3 -> DPRAM
  localparam logic OPWRITE = 1'b1;  // DPRAM -> DDR3

  localparam int ADDR_W           = 28;
  localparam int ID_W             = 3;
  localparam int WDOG_W           = 32;
  localparam int PAGE_BURSTS      = 256;
  localparam int BURST_ADDR_UNITS = 8;
  localparam int PAGE_ADDR_UNITS  = PAGE_BURSTS * BURST_ADDR_UNITS;

  // Next requester index after idx, wrapping at n.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/ddr3_pg_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after
// i_rr_ptr, wrapping modulo N_REQ. i_rr_ptr is assumed to be < N_REQ.
module rr_pick
  import ddr3_pg_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_index
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [3:0]         w_hit;

  // Search a doubled request vector for the first set bit at or above the
  // pointer; the upper copy supplies the wrapped-around candidates.
  always_comb begin
    w_dbl = {i_req, i_req};
    w_hit = '0;
    for (int k = 2*N_REQ-1; k >= 0; k--) begin
      if (w_dbl[k] && (k >= int'(i_rr_ptr))) w_hit = 4'(k);
    end
    if (w_hit >= 4'(N_REQ)) w_hit = w_hit - 4'(N_REQ);
    o_valid = |i_req;
    o_index = w_hit[ID_W-1:0];
  end

endmodule

// File: rtl/ddr3_pg_arbiter.sv
// Round-robin arbiter granting one of N_REQ page-transfer requesters access
// to a single DDR3 page transfer controller, with a four-phase handshake on
// both sides and a non-aborting watchdog.
module ddr3_pg_arbiter
  import ddr3_pg_pkg::*;
#(
  parameter int          N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_optype,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    pg_req,
  output logic                    pg_optype,
  output logic [ADDR_W-1:0]       pg_req_addr,
  input  logic                    pg_ack,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam logic [WDOG_W:0] TO_LIM = (WDOG_W+1)'(TIMEOUT_CYCLES);

  // Initial values keep every output defined before the first reset.
  state_t              r_state     = S_IDLE;
  state_t              w_next;
  logic [ID_W-1:0]     r_rr_ptr    = '0;
  logic [ID_W-1:0]     r_grant_id  = '0;
  logic                r_pg_optype = OPREAD;
  logic [ADDR_W-1:0]   r_pg_addr   = '0;
  logic [WDOG_W-1:0]   r_wdog      = '0;
  logic                r_timeout   = 1'b0;

  logic                w_pick_valid;
  logic [ID_W-1:0]     w_pick_idx;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_sel_op;
  logic [N_REQ-1:0]    w_gnt_onehot;
  logic                w_gnt_req;
  logic                w_grant;
  logic                w_in_xfer;
  logic [WDOG_W:0]     w_wdog_inc;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_index  (w_pick_idx)
  );

  // Granting waits for pg_ack low so a controller left acking by a reset
  // mid-transfer can never see pg_req rise underneath its ack.
  assign w_grant    = (r_state == S_IDLE) && w_pick_valid && !pg_ack;
  assign w_in_xfer  = (r_state == S_XFER) || (r_state == S_XFER_END);
  assign w_gnt_req  = |(req & w_gnt_onehot);
  assign w_wdog_inc = {1'b0, r_wdog} + {{WDOG_W{1'b0}}, 1'b1};

  // Operation and address of the requester the picker selects.
  always_comb begin
    w_sel_addr = '0;
    w_sel_op   = OPREAD;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_idx == ID_W'(i)) begin
        w_sel_addr = req_addr[ADDR_W*i +: ADDR_W];
        w_sel_op   = req_optype[i];
      end
    end
  end

  // One-hot decode of the granted requester.
  always_comb begin
    w_gnt_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_gnt_onehot[i] = (r_grant_id == ID_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic for the two handshakes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_grant)    w_next = S_XFER;
      S_XFER:     if (pg_ack)     w_next = S_XFER_END;
      S_XFER_END: if (!pg_ack)    w_next = S_REQ_ACK;
      S_REQ_ACK:  if (!w_gnt_req) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    pg_req  = (r_state == S_XFER);
    req_ack = (r_state == S_REQ_ACK) ? w_gnt_onehot : '0;
    busy    = (r_state != S_IDLE);
  end

  // Latch the granted request; later changes on any requester are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_id  <= '0;
      r_pg_optype <= OPREAD;
      r_pg_addr   <= '0;
    end else if (w_grant) begin
      r_grant_id  <= w_pick_idx;
      r_pg_optype <= w_sel_op;
      r_pg_addr   <= w_sel_addr;
    end
  end

  // Round-robin pointer moves past the grantee once its ack handshake closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if ((r_state == S_REQ_ACK) && !w_gnt_req) begin
      r_rr_ptr <= wrap_inc(r_grant_id, N_REQ);
    end
  end

  // Watchdog: flags a slow controller but never aborts the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (w_grant) begin
      r_wdog <= '0;
    end else if (w_in_xfer) begin
      if (r_wdog != '1)          r_wdog    <= r_wdog + 1'b1;
      if (w_wdog_inc >= TO_LIM)  r_timeout <= 1'b1;
    end
  end

  assign grant_id    = r_grant_id;
  assign pg_optype   = r_pg_optype;
  assign pg_req_addr = r_pg_addr;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_ddr3_pg_arbiter.sv
// Bench for ddr3_pg_arbiter: directed scenarios followed by randomized
// requesters and a randomized downstream controller, all outputs compared
// every cycle against a transaction-level reference model.
module tb_ddr3_pg_arbiter;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_optype = '0;
  logic [AW*N-1:0] req_addr = '0;
  logic          pg_ack = 1'b0;
  logic [N-1:0]  req_ack;
  logic          pg_req;
  logic          pg_optype;
  logic [AW-1:0] pg_req_addr;
  logic [2:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  ddr3_pg_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_optype  (req_optype),
    .req_addr    (req_addr),
    .req_ack     (req_ack),
    .pg_req      (pg_req),
    .pg_optype   (pg_optype),
    .pg_req_addr (pg_req_addr),
    .pg_ack      (pg_ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction record.
  bit          m_busy, m_pgreq, m_reqack, m_to, m_opt;
  int          m_gid, m_rr;
  logic [AW-1:0] m_addr;
  longint      m_c;
  int          m_wait [N];
  int          grant_log [$];
  bit          prev_pg_req;

  // Stimulus knobs.
  bit auto_raise = 0;
  bit rand_ds    = 0;
  bit ds_hold    = 0;
  int ds_lim     = 2;
  int ds_cnt     = 0;

  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_pgreq = 0; m_reqack = 0; m_to = 0; m_opt = 0;
    m_gid = 0; m_rr = 0; m_addr = '0; m_c = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  task automatic step();
    logic [N-1:0] rq;
    logic ak, rs;
    int pick;
    logic [N-1:0] exp_ack;
    logic [31:0] rnd;
    @(posedge clk);
    #1;
    rq = req; ak = pg_ack; rs = rst;

    // Model update from the inputs the DUT just sampled.
    if (rs) begin
      model_clear();
    end else begin
      if (m_busy && !m_reqack) begin
        if (m_c < 64'hFFFF_FFFF) m_c++;
        if (m_c >= TO) m_to = 1;
      end
      if (!m_busy) begin
        pick = rr_model(rq, m_rr);
        if (pick >= 0 && !ak) begin
          chk_eq("rr_fairness", (m_wait[pick] <= N-1), 1);
          for (int j = 0; j < N; j++) if (j != pick && rq[j]) m_wait[j]++;
          m_wait[pick] = 0;
          grant_log.push_back(pick);
          m_busy = 1; m_pgreq = 1; m_gid = pick; m_c = 0;
          m_addr = req_addr[AW*pick +: AW];
          m_opt  = req_optype[pick];
        end
      end else if (m_pgreq) begin
        if (ak) m_pgreq = 0;
      end else if (!m_reqack) begin
        if (!ak) m_reqack = 1;
      end else if (!rq[m_gid]) begin
        m_reqack = 0; m_busy = 0; m_rr = (m_gid + 1) % N;
      end
    end

    exp_ack = '0;
    if (m_reqack) exp_ack[m_gid] = 1'b1;
    chk_eq("pg_req",      pg_req,      m_pgreq);
    chk_eq("pg_optype",   pg_optype,   m_opt);
    chk_eq("pg_req_addr", pg_req_addr, m_addr);
    chk_eq("grant_id",    grant_id,    m_gid);
    chk_eq("req_ack",     req_ack,     exp_ack);
    chk_eq("busy",        busy,        m_busy);
    chk_eq("timeout_err", timeout_err, m_to);
    chk_eq("ack_onehot0", $onehot0(req_ack), 1);
    chk_eq("rise_vs_ack", (pg_req && !prev_pg_req && ak), 0);
    prev_pg_req = pg_req;

    // Requesters: always drop on ack; optionally raise and perturb at random.
    for (int i = 0; i < N; i++) begin
      if (req[i] && req_ack[i]) begin
        req[i] = 1'b0;
      end else if (auto_raise) begin
        rnd = $urandom;
        if (!req[i] && !req_ack[i] && rnd[1:0] == 2'd0) begin
          req[i] = 1'b1;
          req_optype[i] = rnd[2];
          req_addr[AW*i +: AW] = {rnd[19:3], 11'h000};
        end else if (req[i] && rnd[3:0] == 4'd0) begin
          req_optype[i] = rnd[4];
          req_addr[AW*i +: AW] = {rnd[21:5], 11'h000};
        end else if (req[i] && pg_req && grant_id == 3'(i) && $urandom_range(0, 199) == 0) begin
          req[i] = 1'b0;
        end
      end
    end

    // Downstream page transfer controller.
    if (ds_hold) begin
      pg_ack = 1'b1;
    end else if (pg_ack) begin
      if (!pg_req && $urandom_range(0, 1) == 0) pg_ack = 1'b0;
    end else if (pg_req) begin
      if (ds_cnt >= ds_lim) begin pg_ack = 1'b1; ds_cnt = 0; end
      else ds_cnt++;
    end else begin
      ds_cnt = 0;
      if (rand_ds) ds_lim = $urandom_range(0, 6);
    end
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k;
    k = 0;
    while ((busy || req != '0 || pg_ack) && k < lim) begin
      step();
      k++;
    end
    chk_eq(tag, (busy || req != '0 || pg_ack), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    grant_log.delete();
  endtask

  initial begin
    model_clear();
    prev_pg_req = 0;

    // Reset state.
    step();
    step();
    chk_eq("rst_pg_req", pg_req, 0);
    chk_eq("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Single write request from requester 2, controller acks after 40 cycles.
    ds_lim = 40;
    req[2] = 1'b1; req_optype[2] = 1'b1; req_addr[AW*2 +: AW] = 28'h0000800;
    step();
    chk_eq("d1_pg_req", pg_req, 1);
    chk_eq("d1_addr", pg_req_addr, 28'h0000800);
    chk_eq("d1_optype", pg_optype, 1);
    chk_eq("d1_grant", grant_id, 2);
    for (int k = 0; k < 100 && !req_ack[2]; k++) step();
    chk_eq("d1_req_ack", req_ack, 4'b0100);
    wait_idle("d1_idle_wait", 50);
    ds_lim = 2;
    req[0] = 1'b1; req_addr[0 +: AW] = 28'h0001000;
    req[3] = 1'b1; req_addr[AW*3 +: AW] = 28'h0003000;
    step();
    chk_eq("d1_rr_next", grant_id, 3);
    wait_idle("d1b_idle_wait", 100);

    // All four request together straight after reset.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b1;
      req_optype[i] = i[0];
      req_addr[AW*i +: AW] = 28'(i * 2048);
    end
    wait_idle("d2_idle_wait", 400);
    chk_eq("d2_count", grant_log.size(), 4);
    for (int i = 0; i < N && i < grant_log.size(); i++)
      chk_eq($sformatf("d2_order%0d", i), grant_log[i], i);

    // A pending requester changes its address during another transfer.
    do_reset();
    ds_lim = 10;
    req[0] = 1'b1; req_addr[0 +: AW] = 28'h0000000;
    req[1] = 1'b1; req_addr[AW +: AW] = 28'h0000800;
    step();
    req_addr[AW +: AW] = 28'h1234000;
    for (int k = 0; k < 50 && pg_req; k++) begin
      chk_eq("d3_addr_hold", pg_req_addr, 28'h0000000);
      step();
    end
    for (int k = 0; k < 100 && !(pg_req && grant_id == 3'd1); k++) step();
    chk_eq("d3_new_addr", pg_req_addr, 28'h1234000);
    wait_idle("d3_idle_wait", 100);

    // Controller stalls past the watchdog limit, then acks late.
    do_reset();
    ds_lim = 150;
    req[1] = 1'b1; req_optype[1] = 1'b0; req_addr[AW +: AW] = 28'h0004000;
    step();
    chk_eq("d4_rise", pg_req, 1);
    repeat (TO - 1) step();
    chk_eq("d4_before_limit", timeout_err, 0);
    step();
    chk_eq("d4_at_limit", timeout_err, 1);
    chk_eq("d4_pg_req_held", pg_req, 1);
    wait_idle("d4_idle_wait", 200);
    chk_eq("d4_sticky", timeout_err, 1);

    // Reset while the controller is acking.
    ds_lim = 3;
    req[3] = 1'b1; req_addr[AW*3 +: AW] = 28'h0008000;
    step();
    for (int k = 0; k < 20 && !pg_ack; k++) step();
    chk_eq("d5_ack_seen", pg_ack, 1);
    ds_hold = 1;
    rst = 1'b1;
    step();
    chk_eq("d5_pg_req_drop", pg_req, 0);
    chk_eq("d5_req_ack_drop", req_ack, 0);
    rst = 1'b0;
    repeat (4) begin
      step();
      chk_eq("d5_hold_off", pg_req, 0);
    end
    ds_hold = 0;
    for (int k = 0; k < 20 && !pg_req; k++) step();
    chk_eq("d5_regrant", pg_req, 1);
    chk_eq("d5_ack_low", pg_ack, 0);
    wait_idle("d5_idle_wait", 100);

    // Randomized traffic.
    auto_raise = 1;
    rand_ds    = 1;
    repeat (3000) step();
    auto_raise = 0;
    wait_idle("rand_idle_wait", 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: observed no end of test, expected end within 1000000");
    $fatal(1);
  end

endmodule
